mips: RTL and testbench

- Single-cycle 32-bit MIPS subset processor core with separate (Harvard) instruction and data memory ports.
- Memories are external to the block.
- Each clock executes one instruction:
  - fetch from the instruction port
  - register read, ALU
  - optional data access
  - register writeback and PC update
- Top-level CPU block of the design, driven directly by the system memories.

---
 rtl/mips.sv | 167 ++++++++++++++++
 tb/tb_mips.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mips.sv
// Single-cycle MIPS subset core: one instruction fetched, executed and retired per IM_CLK edge.
// Instruction and data memories are external; every output is combinational from PC and IM_DATA.
module mips #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        IM_CLK,
  input  logic        DM_CLK,
  input  logic        Z_R,
  output logic [31:0] IM_ADDR,
  input  logic [31:0] IM_DATA,
  output logic        DM_WE,
  output logic [31:0] DM_ADDR,
  output logic [31:0] DM_WR_DATA,
  input  logic [31:0] DM_RD_DATA
);
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
  typedef enum logic [1:0] {WB_ALU, WB_LUI, WB_MEM, WB_LINK} wb_sel_t;

  logic [DATA_W-1:0]        pc;
  logic [DATA_W-1:0]        regs [0:31];

  logic [5:0]               opcode;
  logic [5:0]               funct;
  logic [4:0]               rs_a;
  logic [4:0]               rt_a;
  logic [4:0]               rd_a;
  logic [15:0]              imm;
  logic [25:0]              target;

  logic signed [DATA_W-1:0] rs_val;
  logic signed [DATA_W-1:0] rt_val;
  logic signed [DATA_W-1:0] imm_sx;
  logic signed [DATA_W-1:0] imm_zx;
  logic signed [DATA_W-1:0] alu_b;
  logic signed [DATA_W-1:0] alu_res;

  logic [DATA_W-1:0]        pc_plus4;
  logic [DATA_W-1:0]        br_target;
  logic [DATA_W-1:0]        jmp_target;
  logic [DATA_W-1:0]        pc_next;
  logic [DATA_W-1:0]        wr_data;
  logic [4:0]               wr_addr;
  logic                     rf_we;
  logic                     is_sw;
  alu_op_t                  alu_op;
  wb_sel_t                  wb_sel;

  logic                     unused_dm_clk;
  assign unused_dm_clk = DM_CLK;

  function automatic logic signed [DATA_W-1:0] alu(
    input alu_op_t                  op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    case (op)
      ALU_SUB: alu = a - b;
      ALU_AND: alu = a & b;
      ALU_OR:  alu = a | b;
      ALU_SLT: alu = (a < b) ? DATA_W'(1) : '0;
      default: alu = a + b;
    endcase
  endfunction

  assign opcode = IM_DATA[31:26];
  assign rs_a   = IM_DATA[25:21];
  assign rt_a   = IM_DATA[20:16];
  assign rd_a   = IM_DATA[15:11];
  assign funct  = IM_DATA[5:0];
  assign imm    = IM_DATA[15:0];
  assign target = IM_DATA[25:0];

  // $0 is hardwired to zero on the read side, so its storage never matters.
  assign rs_val = (rs_a == 5'd0) ? '0 : regs[rs_a];
  assign rt_val = (rt_a == 5'd0) ? '0 : regs[rt_a];
  assign imm_sx = {{16{imm[15]}}, imm};
  assign imm_zx = {16'h0000, imm};

  assign pc_plus4   = pc + 32'd4;
  assign br_target  = pc_plus4 + {imm_sx[29:0], 2'b00};
  assign jmp_target = {pc_plus4[31:28], target, 2'b00};

  assign alu_res = alu(alu_op, rs_val, alu_b);

  always_comb begin
    alu_op  = ALU_ADD;
    alu_b   = imm_sx;
    wb_sel  = WB_ALU;
    wr_addr = rt_a;
    rf_we   = 1'b0;
    is_sw   = 1'b0;
    pc_next = pc_plus4;
    case (opcode)
      6'h00: begin
        alu_b   = rt_val;
        wr_addr = rd_a;
        rf_we   = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_op = ALU_ADD;
          6'h22, 6'h23: alu_op = ALU_SUB;
          6'h24:        alu_op = ALU_AND;
          6'h25:        alu_op = ALU_OR;
          6'h2A:        alu_op = ALU_SLT;
          default:      rf_we  = 1'b0;
        endcase
      end
      6'h08, 6'h09: rf_we = 1'b1;
      6'h0C: begin
        alu_op = ALU_AND;
        alu_b  = imm_zx;
        rf_we  = 1'b1;
      end
      6'h0D: begin
        alu_op = ALU_OR;
        alu_b  = imm_zx;
        rf_we  = 1'b1;
      end
      6'h0F: begin
        wb_sel = WB_LUI;
        rf_we  = 1'b1;
      end
      6'h23: begin
        wb_sel = WB_MEM;
        rf_we  = 1'b1;
      end
      6'h2B: is_sw = 1'b1;
      6'h04: if (rs_val == rt_val) pc_next = br_target;
      6'h05: if (rs_val != rt_val) pc_next = br_target;
      6'h02: pc_next = jmp_target;
      6'h03: begin
        pc_next = jmp_target;
        wb_sel  = WB_LINK;
        wr_addr = 5'd31;
        rf_we   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_data = alu_res;
    case (wb_sel)
      WB_LUI:  wr_data = {imm, 16'h0000};
      WB_MEM:  wr_data = DM_RD_DATA;
      WB_LINK: wr_data = pc_plus4;
      default: wr_data = alu_res;
    endcase
  end

  assign IM_ADDR    = pc;
  assign DM_ADDR    = rs_val + imm_sx;
  assign DM_WR_DATA = rt_val;
  assign DM_WE      = is_sw & ~Z_R;

  // Retire stage: PC update and register writeback share the same edge.
  always_ff @(posedge IM_CLK) begin
    if (Z_R) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (rf_we && (wr_addr != 5'd0)) regs[wr_addr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_mips.sv
// Directed bench for the mips core: a hand-assembled program is fed one word per cycle
// and the fetch address and data-port outputs are compared with hand-computed values.
module tb_mips;
  logic        clk = 1'b0;
  logic        z_r;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wr_data;
  logic [31:0] dm_rd_data;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mips #(.RESET_PC(32'h0000_0000)) dut (
    .IM_CLK    (clk),
    .DM_CLK    (clk),
    .Z_R       (z_r),
    .IM_ADDR   (im_addr),
    .IM_DATA   (im_data),
    .DM_WE     (dm_we),
    .DM_ADDR   (dm_addr),
    .DM_WR_DATA(dm_wr_data),
    .DM_RD_DATA(dm_rd_data)
  );

  function automatic logic [31:0] r_op(input logic [5:0] fn, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] tg);
    return {op, tg};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Present one instruction at the falling edge, then compare the fetch address.
  task automatic step(input logic [31:0] instr, input logic rst, input logic [31:0] exp_pc);
    @(negedge clk);
    z_r     = rst;
    im_data = instr;
    #1;
    check("im_addr", im_addr, exp_pc);
  endtask

  task automatic check_sw(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_we"}, {31'h0, dm_we}, 32'h1);
    check({tag, "_addr"}, dm_addr, addr);
    check({tag, "_data"}, dm_wr_data, data);
  endtask

  initial begin
    z_r        = 1'b1;
    im_data    = i_op(6'h2B, 5'd0, 5'd0, 16'h0000);
    dm_rd_data = 32'h0;
    #1;
    check("we_in_reset0", {31'h0, dm_we}, 32'h0);
    @(posedge clk);

    step(i_op(6'h2B, 5'd0, 5'd0, 16'h0000), 1'b1, 32'h0);
    check("we_in_reset1", {31'h0, dm_we}, 32'h0);
    step(32'h0, 1'b0, 32'h0);
    check("we_nop", {31'h0, dm_we}, 32'h0);
    step(32'h0, 1'b0, 32'h4);
    step(32'h0, 1'b0, 32'h8);
    step(j_op(6'h02, 26'h40), 1'b0, 32'hC);

    step(i_op(6'h08, 5'd0, 5'd1, 16'd5), 1'b0, 32'h100);
    check("we_addi", {31'h0, dm_we}, 32'h0);
    step(i_op(6'h08, 5'd0, 5'd2, 16'd7), 1'b0, 32'h104);
    step(r_op(6'h20, 5'd1, 5'd2, 5'd3), 1'b0, 32'h108);
    step(i_op(6'h2B, 5'd0, 5'd3, 16'h0010), 1'b0, 32'h10C);
    check_sw("sw_sum", 32'h10, 32'd12);

    dm_rd_data = 32'hDEAD_BEEF;
    step(i_op(6'h23, 5'd0, 5'd4, 16'h0004), 1'b0, 32'h110);
    check("lw_addr", dm_addr, 32'h4);
    check("lw_we", {31'h0, dm_we}, 32'h0);
    step(i_op(6'h2B, 5'd0, 5'd4, 16'h0008), 1'b0, 32'h114);
    dm_rd_data = 32'h0;
    check_sw("sw_lw", 32'h8, 32'hDEAD_BEEF);
    step(j_op(6'h02, 26'h8), 1'b0, 32'h118);

    step(i_op(6'h08, 5'd0, 5'd1, 16'd3), 1'b0, 32'h20);
    step(i_op(6'h04, 5'd1, 5'd1, 16'd2), 1'b0, 32'h24);
    step(j_op(6'h02, 26'h8), 1'b0, 32'h30);
    step(i_op(6'h08, 5'd0, 5'd1, 16'd3), 1'b0, 32'h20);
    step(i_op(6'h05, 5'd1, 5'd1, 16'd2), 1'b0, 32'h24);

    step(i_op(6'h08, 5'd0, 5'd0, 16'd9), 1'b0, 32'h28);
    step(i_op(6'h2B, 5'd0, 5'd0, 16'h0000), 1'b0, 32'h2C);
    check_sw("sw_r0", 32'h0, 32'h0);

    step(i_op(6'h08, 5'd0, 5'd1, 16'hFFFF), 1'b0, 32'h30);
    step(i_op(6'h08, 5'd0, 5'd2, 16'd1), 1'b0, 32'h34);
    step(r_op(6'h2A, 5'd1, 5'd2, 5'd3), 1'b0, 32'h38);
    step(i_op(6'h2B, 5'd0, 5'd3, 16'h0000), 1'b0, 32'h3C);
    check_sw("slt_lt", 32'h0, 32'h1);
    step(r_op(6'h2A, 5'd2, 5'd1, 5'd5), 1'b0, 32'h40);
    step(i_op(6'h2B, 5'd0, 5'd5, 16'h0000), 1'b0, 32'h44);
    check_sw("slt_ge", 32'h0, 32'h0);

    step(i_op(6'h0F, 5'd0, 5'd6, 16'h1234), 1'b0, 32'h48);
    step(i_op(6'h0D, 5'd6, 5'd6, 16'h8765), 1'b0, 32'h4C);
    step(i_op(6'h2B, 5'd0, 5'd6, 16'h0000), 1'b0, 32'h50);
    check_sw("lui_ori", 32'h0, 32'h1234_8765);
    step(i_op(6'h0C, 5'd6, 5'd7, 16'hFF00), 1'b0, 32'h54);
    step(r_op(6'h22, 5'd7, 5'd1, 5'd8), 1'b0, 32'h58);
    step(i_op(6'h2B, 5'd0, 5'd8, 16'h0000), 1'b0, 32'h5C);
    check_sw("andi_sub", 32'h0, 32'h0000_8701);
    step(r_op(6'h24, 5'd8, 5'd6, 5'd9), 1'b0, 32'h60);
    step(i_op(6'h2B, 5'd6, 5'd9, 16'hFFFC), 1'b0, 32'h64);
    check_sw("and_negoff", 32'h1234_8761, 32'h0000_8701);

    step(j_op(6'h03, 26'h6), 1'b0, 32'h68);
    step(i_op(6'h2B, 5'd0, 5'd31, 16'h0000), 1'b0, 32'h18);
    check_sw("jal_link", 32'h0, 32'h6C);
    step(j_op(6'h02, 26'h6), 1'b0, 32'h1C);

    step(i_op(6'h2B, 5'd0, 5'd6, 16'h0000), 1'b1, 32'h18);
    check("we_mid_reset", {31'h0, dm_we}, 32'h0);
    step(i_op(6'h2B, 5'd0, 5'd1, 16'h0000), 1'b0, 32'h0);
    check_sw("rst_r1", 32'h0, 32'h0);
    step(i_op(6'h2B, 5'd0, 5'd31, 16'h0000), 1'b0, 32'h4);
    check_sw("rst_r31", 32'h0, 32'h0);
    step(i_op(6'h2B, 5'd0, 5'd6, 16'h0000), 1'b0, 32'h8);
    check_sw("rst_r6", 32'h0, 32'h0);
    step(32'h0, 1'b0, 32'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
